alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Parametrised successor to the single-slot integer ALU.
- Accepts one calculation per accept phase from the reservation station and computes the result in the same edge.
- Results are queued in a RB_DEPTH-entry result FIFO; the head entry is written back to the instruction queue, one per writeback phase.
- Adds data-width generalisation, an extended opcode set, a one-cycle write-enable pulse, a flush and a sticky overflow flag.

Parameters:
XLEN, 32, operand/result width.
IQ_ADDR_W, 5, instruction-queue index width.
CALC_W, 5, calc-code width.
RB_DEPTH, 4, result FIFO entries; power of two, >=2.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-low.
rdy  in  1  global ready. Low: all state and outputs hold, except the rst and clear_flag_in effects.
update_stat  in  1  phase select: 1 = accept phase, 0 = writeback phase.
clear_flag_in  in  1  pipeline flush request.
rs_calc_enable_in  in  1  RS presents an operation.
rs_calc_code_in  in  CALC_W  opcode.
rs_lhs_in  in  XLEN  left operand.
rs_rhs_in  in  XLEN  right operand.
rs_pos_in_iq_in  in  IQ_ADDR_W  destination IQ index.
rs_full_out  out  1  FIFO cannot accept (combinational).
iq_write_enable_out  out  1  one-cycle writeback strobe.
iq_write_idx_out  out  IQ_ADDR_W  IQ index being written.
iq_write_result_out  out  XLEN  result value.
iq_write_ready_out  out  1  mark entry ready; equals iq_write_enable_out.
iq_write_need_cdb_out  out  1  request CDB broadcast; equals iq_write_enable_out.
ovf_err_out  out  1  sticky: an enable arrived while full.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO count, read pointer and write pointer = 0.
  - All iq_write_* outputs = 0; ovf_err_out = 0.
- rs_full_out = (count == RB_DEPTH). It is combinational from count only.
- Accept, on an edge with rdy=1, update_stat=1, rs_calc_enable_in=1, !rs_full_out, !clear_flag_in:
  - compute the result and push {pos, result} at the write pointer;
  - write pointer increments mod RB_DEPTH; count +1.
- Enable while full: the operation is dropped, ovf_err_out <= 1, and state is unchanged. ovf_err_out clears only on reset.
- Opcodes (shift amount = rhs[$clog2(XLEN)-1:0]):
  - 0 add; 1 sub; 2 sll; 3 slt (signed); 4 sltu; 5 xor; 6 srl; 7 sra; 8 or; 9 and;
  - 10 eq; 11 ne; 12 lt; 13 ge; 14 ltu; 15 geu (compare results are zero-extended 1/0);
  - 16 pass rhs (LUI); 17 (lhs+rhs) with bit0 cleared (JALR target);
  - 18 and above produce 0.
- Arithmetic wraps mod 2^XLEN.
- Writeback, on an edge with rdy=1, update_stat=0, !clear_flag_in, count>0:
  - iq_write_enable_out/ready/need_cdb <= 1;
  - idx and result <= head entry;
  - read pointer +1 mod RB_DEPTH; count -1.
- Strobe deassertion: on any other enabled edge, the enable/ready/need_cdb outputs <= 0. idx and result hold their last values.
- Latency: an op accepted at edge N appears in the earliest writeback phase after N, provided earlier entries have drained. With alternating phases and an empty FIFO, the strobe is visible one cycle after acceptance.
- Flush: clear_flag_in=1 with rdy=1 takes priority over accept and writeback.
  - Count and both pointers <= 0; strobes <= 0.
  - The same-edge RS input is discarded and ovf_err_out is unaffected.
- Push and pop never occur on the same edge because phases are exclusive, so count changes by at most 1 per edge.
- Pointer wrap is tested at RB_DEPTH boundaries.
- Reset mid-operation: an in-flight strobe drops asynchronously and FIFO contents are lost.

Decomposition:
- Shared defines package holds: XLEN default, IQ_ADDR_W, CALC_W, the opcode constants (ALU_ADD..ALU_JALR), and the True/False constants.
- Natural sub-modules:
  - alu_core: purely combinational, opcode plus operands to result, parametrised by XLEN.
  - alu_unit: FIFO, phase control and writeback registers.

Test Plan:
- Reset: assert rst=0 mid-strobe -> all outputs 0 immediately; rs_full_out=0.
- Single op: code 0, lhs=5, rhs=7, pos=3 accepted, then writeback phase -> one-cycle strobe, idx=3, result=12; next writeback phase strobe=0.
- Ops: code 7, lhs=0x80000000, rhs=0x21 -> result 0xC0000000 (shift 1). Code 12, lhs=0xFFFFFFFF, rhs=0 -> 1. Code 14, same operands -> 0. Code 17, lhs=0x1001, rhs=2 -> 0x1002. Code 20 -> 0.
- Full/overflow: 4 accepts with no writeback -> rs_full_out=1; a 5th enable is dropped and ovf_err_out=1. Four writebacks return pos 0..3 in order, and rs_full_out drops after the first.
- Wrap: 6 accept/writeback pairs -> pointers wrap and results stay in order.
- Flush: 3 queued entries, clear_flag_in=1 during a writeback phase -> no strobe, count=0. A subsequent op pos=9 writes back idx=9.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared constants for the integer ALU unit: default widths, opcode map and
// boolean shorthands.
package alu_unit_pkg;

   localparam int DEF_XLEN      = 32;
   localparam int DEF_IQ_ADDR_W = 5;
   localparam int DEF_CALC_W    = 5;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLL  = 2;
   localparam int ALU_SLT  = 3;
   localparam int ALU_SLTU = 4;
   localparam int ALU_XOR  = 5;
   localparam int ALU_SRL  = 6;
   localparam int ALU_SRA  = 7;
   localparam int ALU_OR   = 8;
   localparam int ALU_AND  = 9;
   localparam int ALU_EQ   = 10;
   localparam int ALU_NE   = 11;
   localparam int ALU_LT   = 12;
   localparam int ALU_GE   = 13;
   localparam int ALU_LTU  = 14;
   localparam int ALU_GEU  = 15;
   localparam int ALU_LUI  = 16;
   localparam int ALU_JALR = 17;

endpackage

// File: rtl/alu_unit_core.sv
// Purely combinational integer datapath: opcode plus two operands to one
// XLEN-bit result. Undefined opcodes yield zero.
module alu_core
   import alu_unit_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int CALC_W = DEF_CALC_W
) (
   input  logic [CALC_W-1:0] code,
   input  logic [XLEN-1:0]   lhs,
   input  logic [XLEN-1:0]   rhs,
   output logic [XLEN-1:0]   result
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] sum;
   logic            lt_s;
   logic            lt_u;

   assign shamt = rhs[SHW-1:0];
   assign sum   = lhs + rhs;
   assign lt_s  = $signed(lhs) < $signed(rhs);
   assign lt_u  = lhs < rhs;

   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      result = '0;
      case (code)
         CALC_W'(ALU_ADD):  result = sum;
         CALC_W'(ALU_SUB):  result = lhs - rhs;
         CALC_W'(ALU_SLL):  result = lhs << shamt;
         CALC_W'(ALU_SLT):  result = {{(XLEN-1){1'b0}}, lt_s};
         CALC_W'(ALU_SLTU): result = {{(XLEN-1){1'b0}}, lt_u};
         CALC_W'(ALU_XOR):  result = lhs ^ rhs;
         CALC_W'(ALU_SRL):  result = lhs >> shamt;
         CALC_W'(ALU_SRA):  result = $unsigned($signed(lhs) >>> shamt);
         CALC_W'(ALU_OR):   result = lhs | rhs;
         CALC_W'(ALU_AND):  result = lhs & rhs;
         CALC_W'(ALU_EQ):   result = {{(XLEN-1){1'b0}}, lhs == rhs};
         CALC_W'(ALU_NE):   result = {{(XLEN-1){1'b0}}, lhs != rhs};
         CALC_W'(ALU_LT):   result = {{(XLEN-1){1'b0}}, lt_s};
         CALC_W'(ALU_GE):   result = {{(XLEN-1){1'b0}}, !lt_s};
         CALC_W'(ALU_LTU):  result = {{(XLEN-1){1'b0}}, lt_u};
         CALC_W'(ALU_GEU):  result = {{(XLEN-1){1'b0}}, !lt_u};
         CALC_W'(ALU_LUI):  result = rhs;
         CALC_W'(ALU_JALR): result = {sum[XLEN-1:1], 1'b0};
         default:           result = '0;
      endcase
   end

endmodule

// File: rtl/alu_unit.sv
// ALU unit: computes in the accept phase, queues {pos, result} in a small
// FIFO and writes one entry back to the instruction queue per writeback phase.
module alu_unit
   import alu_unit_pkg::*;
#(
   parameter int XLEN      = DEF_XLEN,
   parameter int IQ_ADDR_W = DEF_IQ_ADDR_W,
   parameter int CALC_W    = DEF_CALC_W,
   parameter int RB_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 update_stat,
   input  logic                 clear_flag_in,
   input  logic                 rs_calc_enable_in,
   input  logic [CALC_W-1:0]    rs_calc_code_in,
   input  logic [XLEN-1:0]      rs_lhs_in,
   input  logic [XLEN-1:0]      rs_rhs_in,
   input  logic [IQ_ADDR_W-1:0] rs_pos_in_iq_in,
   output logic                 rs_full_out,
   output logic                 iq_write_enable_out,
   output logic [IQ_ADDR_W-1:0] iq_write_idx_out,
   output logic [XLEN-1:0]      iq_write_result_out,
   output logic                 iq_write_ready_out,
   output logic                 iq_write_need_cdb_out,
   output logic                 ovf_err_out
);

   localparam int PTR_W = $clog2(RB_DEPTH);
   localparam int CNT_W = $clog2(RB_DEPTH + 1);

   logic [IQ_ADDR_W-1:0] mem_pos [RB_DEPTH];
   logic [XLEN-1:0]      mem_res [RB_DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     count;
   logic [XLEN-1:0]      calc_result;
   logic                 accept_phase;
   logic                 push;
   logic                 pop;
   logic                 drop;

   alu_core #(.XLEN(XLEN), .CALC_W(CALC_W)) u_core (
      .code   (rs_calc_code_in),
      .lhs    (rs_lhs_in),
      .rhs    (rs_rhs_in),
      .result (calc_result)
   );

   assign rs_full_out  = (count == CNT_W'(RB_DEPTH));
   assign accept_phase = rdy && !clear_flag_in && update_stat;
   assign push         = accept_phase && rs_calc_enable_in && !rs_full_out;
   assign drop         = accept_phase && rs_calc_enable_in && rs_full_out;
   assign pop          = rdy && !clear_flag_in && !update_stat && (count != '0);

   assign iq_write_ready_out    = iq_write_enable_out;
   assign iq_write_need_cdb_out = iq_write_enable_out;

   // NOTE: storage carries no reset; count and pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pos[wr_ptr] <= rs_pos_in_iq_in;
         mem_res[wr_ptr] <= calc_result;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count               <= '0;
         rd_ptr              <= '0;
         wr_ptr              <= '0;
         iq_write_enable_out <= FALSE;
         iq_write_idx_out    <= '0;
         iq_write_result_out <= '0;
         ovf_err_out         <= FALSE;
      end else if (rdy) begin
         if (clear_flag_in) begin
            count               <= '0;
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            iq_write_enable_out <= FALSE;
         end else if (pop) begin
            iq_write_enable_out <= TRUE;
            iq_write_idx_out    <= mem_pos[rd_ptr];
            iq_write_result_out <= mem_res[rd_ptr];
            rd_ptr              <= rd_ptr + PTR_W'(1);
            count               <= count - CNT_W'(1);
         end else begin
            iq_write_enable_out <= FALSE;
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
               count  <= count + CNT_W'(1);
            end
            if (drop) ovf_err_out <= TRUE;
         end
      end
   end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed phase sequences plus random traffic
// checked against a queue-level behavioural model.
module tb_alu_unit;

   localparam int XLEN = 32;
   localparam int IQW  = 5;
   localparam int CW   = 5;
   localparam int D    = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            rdy = 1'b1;
   logic            update_stat = 1'b0;
   logic            clear_flag_in = 1'b0;
   logic            rs_calc_enable_in = 1'b0;
   logic [CW-1:0]   rs_calc_code_in = '0;
   logic [XLEN-1:0] rs_lhs_in = '0;
   logic [XLEN-1:0] rs_rhs_in = '0;
   logic [IQW-1:0]  rs_pos_in_iq_in = '0;
   logic            rs_full_out;
   logic            iq_write_enable_out;
   logic [IQW-1:0]  iq_write_idx_out;
   logic [XLEN-1:0] iq_write_result_out;
   logic            iq_write_ready_out;
   logic            iq_write_need_cdb_out;
   logic            ovf_err_out;

   alu_unit #(.XLEN(XLEN), .IQ_ADDR_W(IQW), .CALC_W(CW), .RB_DEPTH(D)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .rdy                   (rdy),
      .update_stat           (update_stat),
      .clear_flag_in         (clear_flag_in),
      .rs_calc_enable_in     (rs_calc_enable_in),
      .rs_calc_code_in       (rs_calc_code_in),
      .rs_lhs_in             (rs_lhs_in),
      .rs_rhs_in             (rs_rhs_in),
      .rs_pos_in_iq_in       (rs_pos_in_iq_in),
      .rs_full_out           (rs_full_out),
      .iq_write_enable_out   (iq_write_enable_out),
      .iq_write_idx_out      (iq_write_idx_out),
      .iq_write_result_out   (iq_write_result_out),
      .iq_write_ready_out    (iq_write_ready_out),
      .iq_write_need_cdb_out (iq_write_need_cdb_out),
      .ovf_err_out           (ovf_err_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IQW-1:0]  idx;
      logic [XLEN-1:0] res;
   } wb_t;

   wb_t  exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   m_cnt = 0;
   logic m_ovf = 1'b0;
   logic m_strobe = 1'b0;
   logic rdy_q = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference semantics written directly from the opcode table.
   function automatic logic [31:0] ref_alu(input int code, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      int signed   sa;
      int signed   sb;
      sh = b % 32;
      sa = a;
      sb = b;
      case (code)
         0:  return a + b;
         1:  return a - b;
         2:  return a << sh;
         3:  return (sa < sb) ? 1 : 0;
         4:  return (a < b) ? 1 : 0;
         5:  return a ^ b;
         6:  return a >> sh;
         7:  return (a >> sh) | ((a >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         8:  return a | b;
         9:  return a & b;
         10: return (a == b) ? 1 : 0;
         11: return (a != b) ? 1 : 0;
         12: return (sa < sb) ? 1 : 0;
         13: return (sa >= sb) ? 1 : 0;
         14: return (a < b) ? 1 : 0;
         15: return (a >= b) ? 1 : 0;
         16: return b;
         17: return (a + b) & 32'hFFFF_FFFE;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) rdy_q <= rdy;

   // Monitor: a fresh strobe is one produced by an enabled edge.
   always @(negedge clk) begin
      if (rst && iq_write_enable_out && rdy_q) begin
         check("wb_ready_eq_en", iq_write_ready_out, 1'b1);
         check("wb_cdb_eq_en", iq_write_need_cdb_out, 1'b1);
         if (exp_q.size() == 0) begin
            check("wb_unexpected", 1'b1, 1'b0);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            check("wb_idx", iq_write_idx_out, e.idx);
            check("wb_result", iq_write_result_out, e.res);
         end
      end
   end

   task automatic step(input logic r, input logic us, input logic en, input logic cl,
                       input int code, input logic [31:0] l, input logic [31:0] rr, input int pos);
      rdy               = r;
      update_stat       = us;
      rs_calc_enable_in = en;
      clear_flag_in     = cl;
      rs_calc_code_in   = CW'(code);
      rs_lhs_in         = l;
      rs_rhs_in         = rr;
      rs_pos_in_iq_in   = IQW'(pos);
      if (r) begin
         if (cl) begin
            m_cnt    = 0;
            m_strobe = 1'b0;
         end else if (us) begin
            m_strobe = 1'b0;
            if (en) begin
               if (m_cnt == D) m_ovf = 1'b1;
               else begin
                  exp_q.push_back('{idx: IQW'(pos), res: ref_alu(code, l, rr)});
                  m_cnt++;
               end
            end
         end else if (m_cnt > 0) begin
            m_strobe = 1'b1;
            m_cnt--;
         end else begin
            m_strobe = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (r && cl) exp_q.delete();
      check("strobe", iq_write_enable_out, m_strobe);
      check("full", rs_full_out, (m_cnt == D));
      check("ovf", ovf_err_out, m_ovf);
   endtask

   task automatic acc(input int code, input logic [31:0] l, input logic [31:0] rr, input int pos);
      step(1'b1, 1'b1, 1'b1, 1'b0, code, l, rr, pos);
   endtask

   task automatic wb();
      step(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 32'h0, 0);
   endtask

   initial begin
      logic [31:0] specials [6];
      specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h21};

      #12;
      check("rst_strobe", iq_write_enable_out, 1'b0);
      check("rst_idx", iq_write_idx_out, '0);
      check("rst_result", iq_write_result_out, '0);
      check("rst_full", rs_full_out, 1'b0);
      check("rst_ovf", ovf_err_out, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single op then two writeback phases.
      acc(0, 32'd5, 32'd7, 3);
      wb();
      wb();

      // Opcode samples.
      acc(7, 32'h8000_0000, 32'h21, 1);      wb();
      acc(12, 32'hFFFF_FFFF, 32'h0, 2);      wb();
      acc(14, 32'hFFFF_FFFF, 32'h0, 4);      wb();
      acc(17, 32'h1001, 32'h2, 5);           wb();
      acc(20, 32'h1234, 32'h5678, 6);        wb();

      // Fill, overflow, drain.
      for (int i = 0; i < 5; i++) acc(1, 32'd100, 32'(i), i);
      for (int i = 0; i < 4; i++) wb();
      wb();

      // Pointer wrap.
      for (int i = 0; i < 6; i++) begin
         acc(0, 32'(i * 3), 32'd1, 10 + i);
         wb();
      end

      // Flush during writeback phase.
      for (int i = 0; i < 3; i++) acc(5, 32'hF0F0, 32'(i), 20 + i);
      step(1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h1, 32'h1, 30);
      wb();
      acc(16, 32'h0, 32'hABCD_0000, 9);
      wb();

      // Asynchronous reset while a strobe is high.
      acc(0, 32'd1, 32'd1, 7);
      acc(0, 32'd2, 32'd2, 8);
      wb();
      #1;
      rst = 1'b0;
      #1;
      check("arst_strobe", iq_write_enable_out, 1'b0);
      check("arst_ready", iq_write_ready_out, 1'b0);
      check("arst_cdb", iq_write_need_cdb_out, 1'b0);
      check("arst_idx", iq_write_idx_out, '0);
      check("arst_result", iq_write_result_out, '0);
      check("arst_full", rs_full_out, 1'b0);
      check("arst_ovf", ovf_err_out, 1'b0);
      exp_q.delete();
      m_cnt    = 0;
      m_ovf    = 1'b0;
      m_strobe = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         step(($urandom_range(0, 7) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 24) == 0), $urandom_range(0, 23), a, b, $urandom_range(0, 31));
      end

      for (int i = 0; i < D + 1; i++) wb();
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
